// File: rtl/tone_pkg.sv
// ============================================================================
// Module  : tone_pkg
// Brief   : Shared widths, note half-period table and FSM states for the
//           tone channel arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tone_pkg;

    localparam int              PW     = 18;
    localparam logic [PW-1:0]   SILENT = 18'd2;

    // Half-periods in clk cycles for a 50 MHz clock
    localparam logic [PW-1:0] c_note_c3 = 18'd191101;
    localparam logic [PW-1:0] c_note_d3 = 18'd170262;
    localparam logic [PW-1:0] c_note_e3 = 18'd151686;
    localparam logic [PW-1:0] c_note_c4 = 18'd95556;
    localparam logic [PW-1:0] c_note_d4 = 18'd85131;
    localparam logic [PW-1:0] c_note_e4 = 18'd75843;
    localparam logic [PW-1:0] c_note_c5 = 18'd47778;
    localparam logic [PW-1:0] c_note_d5 = 18'd42566;
    localparam logic [PW-1:0] c_note_e5 = 18'd37922;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        PEND = 3'd2,
        STOP = 3'd3,
        GAP  = 3'd4
    } tone_state_t;

    function automatic logic is_note(input logic [PW-1:0] period);
        return (period != SILENT) && (period != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational masked round-robin over indices 1..N_REQ-1; returns
//           the first eligible index at or after the pointer, wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
    import tone_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_eff,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_pick
);

    logic w_found;
    // Index 0 is the fixed-priority requester and never rotates
    logic w_unused;
    assign w_unused = i_eff[0];

    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        for (int i = 1; i < N_REQ; i++) begin
            if (!w_found && i_eff[i] && (IDX_W'(i) >= i_ptr)) begin
                o_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
        for (int i = 1; i < N_REQ; i++) begin
            if (!w_found && i_eff[i]) begin
                o_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tone_channel_arbiter.sv
// ============================================================================
// Module  : tone_channel_arbiter
// Brief   : Shares one square-wave divider between note sources; requester 0
//           preempts, the rest rotate with a minimum hold. Period changes are
//           applied only at a divider wrap. Optional TONE_ARB_GAP_EN inserts
//           a silent gap until the next tick when ownership moves.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_channel_arbiter
    import tone_pkg::*;
#(
    parameter int            N_REQ    = 3,
    parameter int            PW       = tone_pkg::PW,
    parameter int            MIN_HOLD = 4,
    parameter int            HOLD_W   = 8,
    parameter logic [PW-1:0] SILENT   = tone_pkg::SILENT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*PW-1:0] req_period,
    input  logic                tone_wrap,
    output logic [PW-1:0]       tone_period,
    output logic                tone_load,
    output logic                tone_en,
    output logic [N_REQ-1:0]    grant,
    output logic                busy
);

    localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  w_eff;
    logic [N_REQ-1:0]  w_pick;
    logic [N_REQ-1:0]  w_grant_nxt;
    logic [PW-1:0]     w_per_nxt;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic              w_own_rot;
    logic              w_own_eff;
    logic              w_peer;

    logic [N_REQ-1:0]  r_grant;
    logic [IDX_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold;

    tone_state_t       r_state, w_state_nxt;
    logic [PW-1:0]     r_tone_period, w_period_nxt;
    logic [PW-1:0]     r_pend, w_pend_nxt;
    logic              r_tone_load, w_load_nxt;
    logic              r_tone_en, w_en_nxt;
    logic              r_busy, w_busy_nxt;
`ifdef TONE_ARB_GAP_EN
    logic              r_gap, w_gap_nxt;
    logic              w_switch;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_eff
            assign w_eff[gi] = req_valid[gi]
                            && (req_period[gi*PW +: PW] != SILENT)
                            && (req_period[gi*PW +: PW] != '0);
        end
    endgenerate

    assign w_own_rot = (r_grant != '0) && !r_grant[0];
    assign w_own_eff = |(r_grant & w_eff);
    assign w_peer    = |(w_eff & ~r_grant & ~N_REQ'(1));

    // While a rotating owner holds, r_ptr already points just past it
    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .i_eff  (w_eff),
        .i_ptr  (r_ptr),
        .o_pick (w_pick)
    );

    always_comb begin
        w_grant_nxt = '0;
        if (w_eff[0]) begin
            w_grant_nxt = N_REQ'(1);
        end else if (w_own_rot && w_own_eff
                     && ((r_hold < HOLD_W'(MIN_HOLD)) || !w_peer)) begin
            w_grant_nxt = r_grant;
        end else begin
            w_grant_nxt = w_pick;
        end
    end

    always_comb begin
        w_per_nxt = '0;
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_nxt[i]) begin
                w_per_nxt = req_period[i*PW +: PW];
            end
        end
        for (int i = 1; i < N_REQ; i++) begin
            if (w_grant_nxt[i]) begin
                w_ptr_nxt = (i == N_REQ - 1) ? IDX_W'(1) : IDX_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_ptr   <= IDX_W'(1);
            r_hold  <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_grant_nxt != r_grant) begin
                r_hold <= '0;
            end else if (tick && w_own_rot && (r_hold != '1)) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_tone_period;
        w_pend_nxt   = r_pend;
        w_load_nxt   = 1'b0;
        w_en_nxt     = r_tone_en;
        w_busy_nxt   = r_busy;
`ifdef TONE_ARB_GAP_EN
        w_gap_nxt    = r_gap;
        w_switch     = (r_grant != '0) && (w_grant_nxt != '0) && (w_grant_nxt != r_grant);
`endif
        case (r_state)
            IDLE: begin
                // Divider is stopped, so a new note can start at once
                if (w_grant_nxt != '0) begin
                    w_period_nxt = w_per_nxt;
                    w_load_nxt   = 1'b1;
                    w_en_nxt     = 1'b1;
                    w_state_nxt  = PLAY;
                end
            end
            PLAY: begin
                if (w_grant_nxt == '0) begin
                    w_state_nxt = STOP;
                end else if ((w_grant_nxt != r_grant) || (w_per_nxt != r_tone_period)) begin
                    w_pend_nxt  = w_per_nxt;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = PEND;
`ifdef TONE_ARB_GAP_EN
                    w_gap_nxt   = w_switch;
`endif
                end
            end
            PEND: begin
                if (w_grant_nxt == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = STOP;
`ifdef TONE_ARB_GAP_EN
                    w_gap_nxt   = 1'b0;
`endif
                end else if (tone_wrap) begin
`ifdef TONE_ARB_GAP_EN
                    if (r_gap || w_switch) begin
                        w_en_nxt    = 1'b0;
                        w_gap_nxt   = 1'b0;
                        w_state_nxt = GAP;
                    end else
`endif
                    begin
                        w_period_nxt = r_pend;
                        w_load_nxt   = 1'b1;
                        w_pend_nxt   = w_per_nxt;
                        // A change arriving with the wrap stays pending
                        if (w_per_nxt == r_pend) begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = PLAY;
                        end
                    end
                end else begin
                    w_pend_nxt = w_per_nxt;
`ifdef TONE_ARB_GAP_EN
                    w_gap_nxt  = r_gap || w_switch;
`endif
                end
            end
            STOP: begin
                if (w_grant_nxt != '0) begin
                    w_pend_nxt  = w_per_nxt;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = PEND;
                end else if (tone_wrap) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
`ifdef TONE_ARB_GAP_EN
            GAP: begin
                if (w_grant_nxt == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (tick) begin
                    w_period_nxt = w_per_nxt;
                    w_load_nxt   = 1'b1;
                    w_en_nxt     = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = PLAY;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_tone_period <= SILENT;
            r_pend        <= SILENT;
            r_tone_load   <= 1'b0;
            r_tone_en     <= 1'b0;
            r_busy        <= 1'b0;
`ifdef TONE_ARB_GAP_EN
            r_gap         <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_tone_period <= w_period_nxt;
            r_pend        <= w_pend_nxt;
            r_tone_load   <= w_load_nxt;
            r_tone_en     <= w_en_nxt;
            r_busy        <= w_busy_nxt;
`ifdef TONE_ARB_GAP_EN
            r_gap         <= w_gap_nxt;
`endif
        end
    end

    assign tone_period = r_tone_period;
    assign tone_load   = r_tone_load;
    assign tone_en     = r_tone_en;
    assign grant       = r_grant;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_tone_channel_arbiter.sv
// ============================================================================
// Module  : tb_tone_channel_arbiter
// Brief   : Randomized bench for tone_channel_arbiter against a behavioural
//           model of ownership and wrap-aligned period updates.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_channel_arbiter;
    import tone_pkg::*;

    localparam int            N_REQ    = 3;
    localparam int            MIN_HOLD = 4;
    localparam int            HOLD_MAX = 255;
    localparam logic [PW-1:0] SIL      = 18'd2;
    localparam int            N_CYC    = 6000;

    logic                clk = 1'b0;
    logic                rst;
    logic                tick;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*PW-1:0] req_period;
    logic                tone_wrap;
    logic [PW-1:0]       tone_period;
    logic                tone_load;
    logic                tone_en;
    logic [N_REQ-1:0]    grant;
    logic                busy;

    tone_channel_arbiter #(
        .N_REQ    (N_REQ),
        .PW       (PW),
        .MIN_HOLD (MIN_HOLD),
        .HOLD_W   (8),
        .SILENT   (SIL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .req_valid   (req_valid),
        .req_period  (req_period),
        .tone_wrap   (tone_wrap),
        .tone_period (tone_period),
        .tone_load   (tone_load),
        .tone_en     (tone_en),
        .grant       (grant),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: owner index (-1 = none), hold ticks, rotation start, and
    // the divider view (running, stopping, pending change)
    int   m_own, m_hold, m_ptr;
    bit   m_en, m_stop, m_busy, m_load;
    int   m_period, m_pend;

    logic [PW-1:0] notes [8] = '{c_note_c4, c_note_d4, c_note_c3, c_note_c5,
                                 SIL, 18'd0, c_note_e4, c_note_c4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int period_of(input int idx);
        logic [PW-1:0] p;
        p = req_period[idx*PW +: PW];
        return int'(p);
    endfunction

    function automatic int next_from(input bit e[N_REQ], input int start);
        for (int k = 0; k < N_REQ - 1; k++) begin
            int idx;
            idx = 1 + ((start - 1 + k) % (N_REQ - 1));
            if (e[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_hold = 0; m_ptr = 1;
        m_en = 0; m_stop = 0; m_busy = 0; m_load = 0;
        m_period = int'(SIL); m_pend = int'(SIL);
    endtask

    task automatic model_step();
        bit e[N_REQ];
        bit peer;
        int nxt, tn;
        for (int i = 0; i < N_REQ; i++)
            e[i] = req_valid[i] && is_note(req_period[i*PW +: PW]);

        if (e[0]) nxt = 0;
        else if (m_own > 0 && e[m_own]) begin
            peer = 0;
            for (int i = 1; i < N_REQ; i++) if (i != m_own && e[i]) peer = 1;
            if (m_hold >= MIN_HOLD && peer) nxt = next_from(e, (m_own % (N_REQ - 1)) + 1);
            else nxt = m_own;
        end else nxt = next_from(e, m_ptr);

        tn = (nxt >= 0) ? period_of(nxt) : 0;
        m_load = 0;
        if (!m_en) begin
            if (nxt >= 0) begin m_period = tn; m_load = 1; m_en = 1; end
        end else if (m_stop) begin
            if (nxt >= 0) begin m_stop = 0; m_busy = 1; m_pend = tn; end
            else if (tone_wrap) begin m_en = 0; m_stop = 0; end
        end else if (nxt < 0) begin
            m_stop = 1; m_busy = 0;
        end else if (m_busy) begin
            if (tone_wrap) begin
                m_period = m_pend; m_load = 1; m_busy = (tn != m_pend);
            end
            m_pend = tn;
        end else if (nxt != m_own || tn != m_period) begin
            m_busy = 1; m_pend = tn;
        end

        if (nxt != m_own) m_hold = 0;
        else if (tick && m_own > 0 && m_hold < HOLD_MAX) m_hold++;
        if (nxt > 0) m_ptr = (nxt % (N_REQ - 1)) + 1;
        m_own = nxt;
    endtask

    task automatic compare_all();
        check("grant",       32'(grant),       (m_own < 0) ? 0 : (1 << m_own));
        check("tone_period", 32'(tone_period), m_period);
        check("tone_load",   32'(tone_load),   32'(m_load));
        check("tone_en",     32'(tone_en),     32'(m_en));
        check("busy",        32'(busy),        32'(m_busy));
    endtask

    task automatic drive_random();
        rst       = ($urandom_range(0, 399) == 0);
        tick      = ($urandom_range(0, 3) == 0);
        tone_wrap = ($urandom_range(0, 5) == 0);
        for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(0, (i == 0) ? 59 : 24) == 0) begin
                req_valid[i] = (i == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
                req_period[i*PW +: PW] = notes[$urandom_range(0, 7)];
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; tone_wrap = 1'b0;
        req_valid = '0; req_period = '0;
        model_reset();
        @(negedge clk);
        check("rst_grant",  32'(grant),       0);
        check("rst_period", 32'(tone_period), 2);
        check("rst_load",   32'(tone_load),   0);
        check("rst_en",     32'(tone_en),     0);
        check("rst_busy",   32'(busy),        0);

        rst = 1'b0;
        req_valid = 3'b010;
        req_period[1*PW +: PW] = c_note_c4;
        model_step();
        @(negedge clk);
        check("first_grant",  32'(grant),       2);
        check("first_load",   32'(tone_load),   1);
        check("first_period", 32'(tone_period), 95556);
        check("first_en",     32'(tone_en),     1);
        compare_all();

        for (int c = 0; c < N_CYC; c++) begin
            drive_random();
            if (rst) model_reset();
            else model_step();
            @(negedge clk);
            compare_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
